// File: rtl/press_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module      : press_pattern_decoder
// Description : Classifies clean button presses as single or double using a
//               programmable window; emits event pulses and saturating tallies.
// Revision    : 1.0 - initial release
// ============================================================================
module press_pattern_decoder #(
    parameter int WINDOW = 1_500_000,
    parameter int TW_W   = 21,
    parameter int CNT_W  = 8
) (
    input  logic             clk5,
    input  logic             reset,
    input  logic             clean,
    input  logic             clear,
    output logic             single,
    output logic             double,
    output logic             busy,
    output logic [CNT_W-1:0] singleCount,
    output logic [CNT_W-1:0] doubleCount
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_WAIT    = 2'd1;
    localparam logic [TW_W-1:0]  TIMER_LAST = TW_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       state_q, state_d;
    logic [TW_W-1:0]  timer_q, timer_d;
    logic             clean_q, clean_d;
    logic             single_q, single_d;
    logic             double_q, double_d;
    logic [CNT_W-1:0] single_count_q, single_count_d;
    logic [CNT_W-1:0] double_count_q, double_count_d;
    logic             rise;

    always_comb begin
        clean_d  = clean;
        rise     = clean & ~clean_q;
        state_d  = state_q;
        timer_d  = timer_q;
        single_d = 1'b0;
        double_d = 1'b0;

        // A second rise takes priority over the timeout, even on the last cycle.
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    single_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        single_count_d = single_count_q;
        double_count_d = double_count_q;
        if (clear) begin
            single_count_d = '0;
            double_count_d = '0;
        end else begin
            if (single_d && (single_count_q != CNT_MAX)) begin
                single_count_d = single_count_q + CNT_W'(1);
            end
            if (double_d && (double_count_q != CNT_MAX)) begin
                double_count_d = double_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            clean_q        <= 1'b0;
            single_q       <= 1'b0;
            double_q       <= 1'b0;
            single_count_q <= '0;
            double_count_q <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            clean_q        <= clean_d;
            single_q       <= single_d;
            double_q       <= double_d;
            single_count_q <= single_count_d;
            double_count_q <= double_count_d;
        end
    end

    assign single      = single_q;
    assign double      = double_q;
    assign busy        = (state_q == ST_WAIT);
    assign singleCount = single_count_q;
    assign doubleCount = double_count_q;

endmodule
`default_nettype wire

// File: tb/tb_press_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_pattern_decoder
// Description : Self-checking bench for press_pattern_decoder (WINDOW = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_pattern_decoder;

    localparam int WINDOW = 8;
    localparam int TW_W   = 4;
    localparam int CNT_W  = 8;

    logic             clk5 = 1'b0;
    logic             reset;
    logic             clean;
    logic             clear;
    logic             single;
    logic             double;
    logic             busy;
    logic [CNT_W-1:0] singleCount;
    logic [CNT_W-1:0] doubleCount;

    int errors = 0;
    int checks = 0;

    // Reference model: an open window is remembered by the edge number it began on.
    int edge_n;
    int m_open;
    bit m_prev;
    bit m_single;
    bit m_double;
    int m_scnt;
    int m_dcnt;

    press_pattern_decoder #(
        .WINDOW(WINDOW),
        .TW_W  (TW_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk5       (clk5),
        .reset      (reset),
        .clean      (clean),
        .clear      (clear),
        .single     (single),
        .double     (double),
        .busy       (busy),
        .singleCount(singleCount),
        .doubleCount(doubleCount)
    );

    always #5 clk5 = ~clk5;

    task automatic model_reset();
        edge_n   = 0;
        m_open   = -1;
        m_prev   = 1'b0;
        m_single = 1'b0;
        m_double = 1'b0;
        m_scnt   = 0;
        m_dcnt   = 0;
    endtask

    task automatic step(input logic c, input logic clr);
        bit rise_v;
        bit ev_s;
        bit ev_d;
        clean = c;
        clear = clr;
        @(posedge clk5);
        edge_n++;
        rise_v = c && !m_prev;
        m_prev = c;
        ev_s   = 1'b0;
        ev_d   = 1'b0;
        if (m_open >= 0) begin
            if (rise_v) begin
                ev_d   = 1'b1;
                m_open = -1;
            end else if (edge_n - m_open == WINDOW) begin
                ev_s   = 1'b1;
                m_open = -1;
            end
        end else if (rise_v) begin
            m_open = edge_n;
        end
        if (clr) begin
            m_scnt = 0;
            m_dcnt = 0;
        end else begin
            if (ev_s && m_scnt < (1 << CNT_W) - 1) m_scnt++;
            if (ev_d && m_dcnt < (1 << CNT_W) - 1) m_dcnt++;
        end
        m_single = ev_s;
        m_double = ev_d;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clean = 1'b0;
        clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk5);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clean = 1'b0;
        clear = 1'b0;
        model_reset();
        #2;
        checks++; if (single !== 1'b0) begin errors++; $display("FAIL reset_single: got %b expected 0", single); end
        checks++; if (double !== 1'b0) begin errors++; $display("FAIL reset_double: got %b expected 0", double); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (singleCount !== 8'd0) begin errors++; $display("FAIL reset_singleCount: got %0d expected 0", singleCount); end
        checks++; if (doubleCount !== 8'd0) begin errors++; $display("FAIL reset_doubleCount: got %0d expected 0", doubleCount); end
        repeat (2) @(posedge clk5);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    // Press at relative edge 10 only; counts assumed zero on entry.
    task automatic test_single();
        int singles;
        singles = 0;
        for (int e = 1; e <= 30; e++) begin
            step(e == 10, 1'b0);
            checks++;
            if (busy !== (e >= 10 && e <= 17)) begin
                errors++; $display("FAIL single_busy@%0d: got %b expected %b", e, busy, (e >= 10 && e <= 17));
            end
            if (single === 1'b1) singles++;
            if (e == 18) begin
                checks++; if (single !== 1'b1) begin errors++; $display("FAIL single_pulse@18: got %b expected 1", single); end
            end
            checks++; if (double !== 1'b0) begin errors++; $display("FAIL single_no_double@%0d: got %b expected 0", e, double); end
        end
        checks++; if (singles != 1) begin errors++; $display("FAIL single_pulse_count: got %0d expected 1", singles); end
        checks++; if (singleCount !== 8'd1) begin errors++; $display("FAIL single_singleCount: got %0d expected 1", singleCount); end
        checks++; if (doubleCount !== 8'd0) begin errors++; $display("FAIL single_doubleCount: got %0d expected 0", doubleCount); end
    endtask

    task automatic test_double();
        int doubles;
        doubles = 0;
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            step(e == 10 || e == 14, 1'b0);
            if (double === 1'b1) doubles++;
            checks++; if (single !== 1'b0) begin errors++; $display("FAIL double_no_single@%0d: got %b expected 0", e, single); end
            if (e == 14) begin
                checks++; if (double !== 1'b1) begin errors++; $display("FAIL double_pulse@14: got %b expected 1", double); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL double_busy@14: got %b expected 0", busy); end
            end
        end
        checks++; if (doubles != 1) begin errors++; $display("FAIL double_pulse_count: got %0d expected 1", doubles); end
        checks++; if (doubleCount !== 8'd1) begin errors++; $display("FAIL double_doubleCount: got %0d expected 1", doubleCount); end
        checks++; if (singleCount !== 8'd0) begin errors++; $display("FAIL double_singleCount: got %0d expected 0", singleCount); end
    endtask

    task automatic test_boundary();
        int singles;
        do_reset();
        singles = 0;
        for (int e = 1; e <= 25; e++) begin
            step(e == 10 || e == 18, 1'b0);
            if (single === 1'b1) singles++;
            if (e == 18) begin
                checks++; if (double !== 1'b1) begin errors++; $display("FAIL bnd_k8_double: got %b expected 1", double); end
            end
        end
        checks++; if (singles != 0) begin errors++; $display("FAIL bnd_k8_no_single: got %0d expected 0", singles); end

        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step(e == 10 || e == 19, 1'b0);
            checks++; if (double !== 1'b0) begin errors++; $display("FAIL bnd_k9_no_double@%0d: got %b expected 0", e, double); end
            if (e == 18) begin
                checks++; if (single !== 1'b1) begin errors++; $display("FAIL bnd_k9_single@18: got %b expected 1", single); end
            end
            if (e == 19) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bnd_k9_busy@19: got %b expected 1", busy); end
            end
            if (e == 27) begin
                checks++; if (single !== 1'b1) begin errors++; $display("FAIL bnd_k9_single@27: got %b expected 1", single); end
            end
        end
        checks++; if (singleCount !== 8'd2) begin errors++; $display("FAIL bnd_k9_singleCount: got %0d expected 2", singleCount); end
    endtask

    task automatic test_hold();
        int singles;
        singles = 0;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step(e >= 10 && e <= 29, 1'b0);
            if (single === 1'b1) singles++;
        end
        checks++; if (singles != 1) begin errors++; $display("FAIL hold_single_count: got %0d expected 1", singles); end
        checks++; if (singleCount !== 8'd1) begin errors++; $display("FAIL hold_singleCount: got %0d expected 1", singleCount); end
    endtask

    task automatic test_saturate_clear();
        do_reset();
        for (int p = 0; p < 260; p++) begin
            step(1'b1, 1'b0);
            repeat (9) step(1'b0, 1'b0);
        end
        checks++; if (singleCount !== 8'd255) begin errors++; $display("FAIL sat_singleCount: got %0d expected 255", singleCount); end
        checks++; if (doubleCount !== 8'd0) begin errors++; $display("FAIL sat_doubleCount: got %0d expected 0", doubleCount); end
        step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        checks++; if (single !== 1'b1) begin errors++; $display("FAIL clear_single_pulse: got %b expected 1", single); end
        checks++; if (singleCount !== 8'd0) begin errors++; $display("FAIL clear_singleCount: got %0d expected 0", singleCount); end
        step(1'b0, 1'b0);
        checks++; if (singleCount !== 8'd0) begin errors++; $display("FAIL clear_hold: got %0d expected 0", singleCount); end
    endtask

    task automatic test_reset_mid_window();
        int events;
        events = 0;
        do_reset();
        for (int e = 1; e <= 12; e++) step(e == 10, 1'b0);
        reset = 1'b1;
        model_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (single !== 1'b0 || double !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b expected 00", single, double); end
        @(posedge clk5);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            step(1'b0, 1'b0);
            if (single === 1'b1 || double === 1'b1 || busy === 1'b1) events++;
        end
        checks++; if (events != 0) begin errors++; $display("FAIL midrst_activity: got %0d expected 0", events); end
        test_single();
    endtask

    task automatic test_random();
        logic c;
        int   mode;
        do_reset();
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 500) % 3;
            if ($urandom_range(0, 2 + 2 * mode) == 0) c = ~c;
            step(c, $urandom_range(0, 49) == 0);
            checks++; if (single !== m_single) begin errors++; $display("FAIL rnd_single@%0d: got %b expected %b", i, single, m_single); end
            checks++; if (double !== m_double) begin errors++; $display("FAIL rnd_double@%0d: got %b expected %b", i, double, m_double); end
            checks++; if (busy !== (m_open >= 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", i, busy, (m_open >= 0)); end
            checks++; if (int'(singleCount) != m_scnt) begin errors++; $display("FAIL rnd_singleCount@%0d: got %0d expected %0d", i, singleCount, m_scnt); end
            checks++; if (int'(doubleCount) != m_dcnt) begin errors++; $display("FAIL rnd_doubleCount@%0d: got %0d expected %0d", i, doubleCount, m_dcnt); end
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_single();
        test_double();
        test_boundary();
        test_hold();
        test_saturate_clear();
        test_reset_mid_window();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
